// File: rtl/stream_to_video.sv
// stream_to_video
// Turns the scaler's bursty pixel stream (data + valid) back into raster
// video timing (hs/vs/de/rgb). Pixels land in an internal FIFO; once the
// FIFO holds PREFILL pixels the timing generator starts and drains one
// pixel per active video cycle, frame after frame.

module stream_to_video #(
  parameter logic [11:0] H_SYNC     = 12'd44,
  parameter logic [11:0] H_BACK     = 12'd148,
  parameter logic [11:0] H_DISP     = 12'd1920,
  parameter logic [11:0] H_FRONT    = 12'd88,
  parameter logic [11:0] V_SYNC     = 12'd5,
  parameter logic [11:0] V_BACK     = 12'd36,
  parameter logic [11:0] V_DISP     = 12'd1080,
  parameter logic [11:0] V_FRONT    = 12'd4,
  parameter int          DATA_WIDTH = 8,
  parameter int          CHANNELS   = 3,
  parameter int          FIFO_DEPTH = 2048,
  parameter int          PREFILL    = 1920
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [DATA_WIDTH*CHANNELS-1:0]   data_i,
  input  logic                             dataValid_i,
  output logic                             dataReady_o,
  output logic                             hs_o,
  output logic                             vs_o,
  output logic                             de_o,
  output logic [DATA_WIDTH*CHANNELS-1:0]   rgb_o,
  output logic                             underflow_o,
  output logic [$clog2(FIFO_DEPTH):0]      level_o
);

  localparam int PW = DATA_WIDTH * CHANNELS;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [11:0] H_TOTAL     = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam logic [11:0] V_TOTAL     = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic [11:0] H_ACT_START = H_SYNC + H_BACK;
  localparam logic [11:0] H_ACT_END   = H_SYNC + H_BACK + H_DISP;
  localparam logic [11:0] V_ACT_START = V_SYNC + V_BACK;
  localparam logic [11:0] V_ACT_END   = V_SYNC + V_BACK + V_DISP;

  localparam logic [LW-1:0] PREFILL_LVL = LW'(PREFILL);
  localparam logic [LW-1:0] DEPTH_LVL   = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [11:0]     h_cnt;
  logic [11:0]     v_cnt;

  logic [PW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;

  logic            empty;
  logic            wr;
  logic            flush;
  logic            run_live;
  logic            hs_raw;
  logic            vs_raw;
  logic            active;
  logic            pop;
  logic            underflow_set;
  logic [PW-1:0]   rgb_next;

  assign empty       = (level == '0);
  assign dataReady_o = (level != DEPTH_LVL);
  assign level_o     = level;
  assign wr          = dataValid_i && dataReady_o;
  // A start while already filling or running throws away whatever is queued
  assign flush       = start && (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: start always (re)enters FILL, FILL waits for the prefill level
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = FILL;
      end
      FILL: begin
        if (start)                     state_next = FILL;
        else if (level >= PREFILL_LVL) state_next = RUN;
      end
      RUN: begin
        if (start) state_next = FILL;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode: raw timing from the counters, FIFO pop and underflow detect
  always_comb begin
    run_live      = (state == RUN) && !start;
    hs_raw        = (h_cnt < H_SYNC);
    vs_raw        = (v_cnt < V_SYNC);
    active        = (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END) &&
                    (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
    pop           = run_live && active && !empty;
    underflow_set = run_live && active && empty;
    rgb_next      = '0;
    if (pop) rgb_next = mem[rd_ptr];
  end

  // Raster counters: free-running only in RUN, otherwise parked at the origin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (run_live) begin
      if (h_cnt == H_TOTAL - 12'd1) begin
        h_cnt <= '0;
        if (v_cnt == V_TOTAL - 12'd1) v_cnt <= '0;
        else                          v_cnt <= v_cnt + 12'd1;
      end else begin
        h_cnt <= h_cnt + 12'd1;
      end
    end else begin
      h_cnt <= '0;
      v_cnt <= '0;
    end
  end

  // Registered video outputs; rgb shares the de edge so the two stay aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_o        <= 1'b0;
      vs_o        <= 1'b0;
      de_o        <= 1'b0;
      rgb_o       <= '0;
      underflow_o <= 1'b0;
    end else begin
      hs_o        <= run_live && hs_raw;
      vs_o        <= run_live && vs_raw;
      de_o        <= run_live && active;
      rgb_o       <= rgb_next;
      underflow_o <= underflow_o || underflow_set;
    end
  end

  // FIFO pointers and occupancy; a flush keeps the write presented on that cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      wr_ptr <= wr ? wr_ptr + AW'(1) : wr_ptr;
      level  <= LW'(wr);
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(wr) - LW'(pop);
    end
  end

  // FIFO storage: plain memory, no reset needed since level guards every read
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= data_i;
  end

endmodule

// File: tb/tb_stream_to_video.sv
// Testbench for stream_to_video using the small raster (H 2/2/4/2, V 1/1/2/1,
// 8-entry FIFO, prefill 4). A queue-based reference model predicts every
// output from the raster position computed arithmetically from the number
// of cycles spent running.

module tb_stream_to_video;

  localparam int H_SY = 2, H_BP = 2, H_DI = 4, H_FP = 2;
  localparam int V_SY = 1, V_BP = 1, V_DI = 2, V_FP = 1;
  localparam int H_TOT = H_SY + H_BP + H_DI + H_FP;
  localparam int V_TOT = V_SY + V_BP + V_DI + V_FP;
  localparam int DEPTH = 8;
  localparam int PRE   = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [23:0] data_i;
  logic        dataValid_i;
  logic        dataReady_o;
  logic        hs_o;
  logic        vs_o;
  logic        de_o;
  logic [23:0] rgb_o;
  logic        underflow_o;
  logic [3:0]  level_o;

  int compared;
  int mismatched;

  typedef enum {M_IDLE, M_FILL, M_RUN} mode_e;
  mode_e       mode;
  int          t_run;
  logic [23:0] q[$];
  logic        exp_hs, exp_vs, exp_de, exp_uf;
  logic [23:0] exp_rgb;

  stream_to_video #(
    .H_SYNC(12'd2), .H_BACK(12'd2), .H_DISP(12'd4), .H_FRONT(12'd2),
    .V_SYNC(12'd1), .V_BACK(12'd1), .V_DISP(12'd2), .V_FRONT(12'd1),
    .DATA_WIDTH(8), .CHANNELS(3), .FIFO_DEPTH(8), .PREFILL(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .data_i(data_i),
    .dataValid_i(dataValid_i),
    .dataReady_o(dataReady_o),
    .hs_o(hs_o),
    .vs_o(vs_o),
    .de_o(de_o),
    .rgb_o(rgb_o),
    .underflow_o(underflow_o),
    .level_o(level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mode    = M_IDLE;
    t_run   = 0;
    q.delete();
    exp_hs  = 1'b0;
    exp_vs  = 1'b0;
    exp_de  = 1'b0;
    exp_uf  = 1'b0;
    exp_rgb = '0;
  endtask

  // One clock of the reference model: predicts the outputs after the next edge
  task automatic model_step(input logic st, input logic vld, input logic [23:0] dat);
    int size0;
    int h;
    int v;
    bit wr;
    bit act;
    size0   = q.size();
    wr      = vld && (size0 != DEPTH);
    exp_hs  = 1'b0;
    exp_vs  = 1'b0;
    exp_de  = 1'b0;
    exp_rgb = '0;
    if (mode == M_RUN && !st) begin
      h   = t_run % H_TOT;
      v   = (t_run / H_TOT) % V_TOT;
      act = (h >= H_SY + H_BP) && (h < H_SY + H_BP + H_DI) &&
            (v >= V_SY + V_BP) && (v < V_SY + V_BP + V_DI);
      exp_hs = (h < H_SY);
      exp_vs = (v < V_SY);
      exp_de = act;
      if (act) begin
        if (size0 > 0) exp_rgb = q.pop_front();
        else           exp_uf  = 1'b1;
      end
      t_run++;
    end
    if (st) begin
      if (mode != M_IDLE) q.delete();
      mode  = M_FILL;
      t_run = 0;
    end else if (mode == M_FILL && size0 >= PRE) begin
      mode  = M_RUN;
      t_run = 0;
    end
    if (wr) q.push_back(dat);
  endtask

  task automatic checkOutput();
    check("hs",        32'(hs_o),        32'(exp_hs));
    check("vs",        32'(vs_o),        32'(exp_vs));
    check("de",        32'(de_o),        32'(exp_de));
    check("rgb",       32'(rgb_o),       32'(exp_rgb));
    check("underflow", 32'(underflow_o), 32'(exp_uf));
    check("level",     32'(level_o),     32'(q.size()));
    check("ready",     32'(dataReady_o), 32'(q.size() != DEPTH));
  endtask

  // Drive one cycle of inputs from a negedge, then check after the edge
  task automatic applyStimulus(input logic st, input logic vld, input logic [23:0] dat);
    start       = st;
    dataValid_i = vld;
    data_i      = dat;
    model_step(st, vld, dat);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  // Reset raised between edges must clear everything without waiting for a clock
  task automatic async_reset_check(input string tag);
    start       = 1'b0;
    dataValid_i = 1'b0;
    data_i      = '0;
    #2 rst = 1'b1;
    #1;
    check({tag, "_hs"},   32'(hs_o),        32'd0);
    check({tag, "_vs"},   32'(vs_o),        32'd0);
    check({tag, "_de"},   32'(de_o),        32'd0);
    check({tag, "_rgb"},  32'(rgb_o),       32'd0);
    check({tag, "_uf"},   32'(underflow_o), 32'd0);
    check({tag, "_lvl"},  32'(level_o),     32'd0);
    check({tag, "_rdy"},  32'(dataReady_o), 32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic found;
    compared    = 0;
    mismatched  = 0;
    rst         = 1'b1;
    start       = 1'b0;
    dataValid_i = 1'b0;
    data_i      = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput();

    // Idle with no start: everything stays quiet
    repeat (5) applyStimulus(1'b0, 1'b0, 24'd0);

    // Fill the FIFO without pops; the ninth valid must be refused
    for (int i = 1; i <= 9; i++) applyStimulus(1'b0, 1'b1, 24'(i));
    check("full_ready", 32'(dataReady_o), 32'd0);
    check("full_level", 32'(level_o),     32'd8);
    applyStimulus(1'b0, 1'b0, 24'd0);
    async_reset_check("rst_full");

    // Start with six pixels only: second active line shows p,p,0,0
    applyStimulus(1'b1, 1'b1, 24'h000001);
    for (int i = 2; i <= 6; i++) applyStimulus(1'b0, 1'b1, 24'(i));
    repeat (120) applyStimulus(1'b0, 1'b0, 24'd0);
    check("starve_uf", 32'(underflow_o), 32'd1);
    async_reset_check("rst_uf");

    // Randomised feed with backpressure across several frames
    applyStimulus(1'b1, 1'b1, 24'($urandom));
    repeat (250) applyStimulus(1'b0, 1'($urandom_range(3, 0) != 0), 24'($urandom));

    // Wait (bounded) for active video, then restart mid-line with a write
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      applyStimulus(1'b0, 1'($urandom_range(3, 0) != 0), 24'($urandom));
      if (de_o) found = 1'b1;
    end
    check("wait_de", 32'(found), 32'd1);
    applyStimulus(1'b1, 1'b1, 24'($urandom));
    check("restart_level", 32'(level_o), 32'd1);
    check("restart_de",    32'(de_o),    32'd0);
    check("restart_hs",    32'(hs_o),    32'd0);
    repeat (120) applyStimulus(1'b0, 1'($urandom_range(3, 0) != 0), 24'($urandom));
    check("feed_no_uf", 32'(underflow_o), 32'd0);

    // Reset mid-frame
    async_reset_check("rst_mid");
    repeat (3) applyStimulus(1'b0, 1'b0, 24'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
